// File: rtl/branch_predictor.sv
// branch_predictor: bimodal / gshare direction predictor built from 2-bit
// saturating counters, with mispredict flagging and branch/mispredict counters.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int GHR_BITS = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid,
  input  logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_idx,
  input  logic                resolve_valid,
  input  logic [IDX_BITS-1:0] resolve_idx,
  input  logic                resolve_br_en,
  input  logic                resolve_pred_taken,
  output logic                mispredict,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          ctr_q [ENTRIES];
  logic [1:0]          ctr_cur_s;
  logic [1:0]          ctr_d;
  logic [IDX_BITS-1:0] ghr_ext_s;
  logic [31:0]         branch_count_q;
  logic [31:0]         branch_count_d;
  logic [31:0]         mispredict_count_q;
  logic [31:0]         mispredict_count_d;
  logic                mispredict_s;

  // The fetch hint only matters to the pipeline; the PC word-offset bits and
  // the upper PC bits never reach the index.
  logic unused_ok;
  assign unused_ok = ^{pred_valid, pred_pc[31:IDX_BITS+2], pred_pc[1:0]};

  // Global history is non-speculative: it shifts in every resolved outcome.
  generate
    if (GHR_BITS > 0) begin : g_ghr
      logic [GHR_BITS-1:0] ghr_q;
      logic [GHR_BITS-1:0] ghr_d;
      logic [GHR_BITS:0]   ghr_shift_s;

      assign ghr_shift_s = {ghr_q, resolve_br_en};
      assign ghr_d       = ghr_shift_s[GHR_BITS-1:0];
      assign ghr_ext_s   = IDX_BITS'(ghr_q);

      // History register: cleared by reset, shifted on each resolve.
      always_ff @(posedge clk) begin
        if (rst) begin
          ghr_q <= '0;
        end else if (resolve_valid) begin
          ghr_q <= ghr_d;
        end else begin
          ghr_q <= ghr_q;
        end
      end
    end else begin : g_no_ghr
      assign ghr_ext_s = '0;
    end
  endgenerate

  // Prediction reads the stored counter directly, so a same-cycle update to
  // the same entry is not bypassed and becomes visible one cycle later.
  assign pred_idx   = pred_pc[IDX_BITS+1:2] ^ ghr_ext_s;
  assign pred_taken = ctr_q[pred_idx][1];

  assign mispredict_s = resolve_valid & (resolve_br_en ^ resolve_pred_taken);
  assign mispredict   = mispredict_s;

  assign ctr_cur_s = ctr_q[resolve_idx];

  // Saturating increment on taken, saturating decrement on not-taken.
  always_comb begin
    ctr_d = ctr_cur_s;
    if (resolve_br_en) begin
      if (ctr_cur_s != 2'b11) begin
        ctr_d = ctr_cur_s + 2'b01;
      end else begin
        ctr_d = 2'b11;
      end
    end else begin
      if (ctr_cur_s != 2'b00) begin
        ctr_d = ctr_cur_s - 2'b01;
      end else begin
        ctr_d = 2'b00;
      end
    end
  end

  // Counter table: reset to weakly not-taken; only the resolved entry moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (resolve_valid) begin
      ctr_q[resolve_idx] <= ctr_d;
    end else begin
      ctr_q[resolve_idx] <= ctr_q[resolve_idx];
    end
  end

  // Next-state for the performance counters; both wrap naturally at 2**32.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (resolve_valid) begin
      branch_count_d = branch_count_q + 32'd1;
    end else begin
      branch_count_d = branch_count_q;
    end
    if (mispredict_s) begin
      mispredict_count_d = mispredict_count_q + 32'd1;
    end else begin
      mispredict_count_d = mispredict_count_q;
    end
  end

  // Performance counter registers; reset wins over a concurrent resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
